// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift_arbiter block.
// Optional feature macro: SHIFT_ARB_ROTATE_EN (adds the PASS2 state for rotates).
package shift_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int SHAMT_W   = 5;
    localparam int DATA_W    = 32;

    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;
    localparam logic TYPE_LOGICAL = 1'b0;
    localparam logic TYPE_ARITH   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
`ifdef SHIFT_ARB_ROTATE_EN
        PASS2 = 2'b01,
`endif
        HOLD  = 2'b10
    } state_e;

    // One-hot port mask for a port index.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic p);
        if (p) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

    // (32 - n) mod 32: the second-pass amount of a rotate.
    function automatic logic [SHAMT_W-1:0] complement_shamt(input logic [SHAMT_W-1:0] n);
        return 5'd0 - n;
    endfunction

endpackage

// File: rtl/Shifter.sv
// Combinational 32-bit barrel shifter.
// Ports: a (operand), shamt (shift amount), dir (0 left / 1 right),
//        typ (0 logical / 1 arithmetic, right shifts only), y (result).
module Shifter
    import shift_arb_pkg::*;
(
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    input  logic        dir,
    input  logic        typ,
    output logic [31:0] y
);

    // Shift selection by direction and type.
    always_comb begin
        y = 32'h0000_0000;
        if (dir == DIR_LEFT) begin
            y = a << shamt;
        end else if (typ == TYPE_ARITH) begin
            y = $signed(a) >>> shamt;
        end else begin
            y = a >> shamt;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter.
// Ports: clk, rst_n, req (request bits), advance (a grant was taken this
//        cycle), grant (winning port index), grant_valid (any request).
// The last-granted register resets to 1 so port 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant,
    output logic       grant_valid
);

    logic last_grant_r;

    // Winner selection: a lone request wins, a tie goes to the port not granted last.
    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_r;
            default: grant = 1'b0;
        endcase
        grant_valid = |req;
    end

    // Remember the winner only when its request is actually accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (advance) begin
            last_grant_r <= grant;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port sequencer/arbiter in front of one shared barrel shifter.
// Port 0 = ALU shift path, port 1 = branch/immediate unit.
// Ports: clk, rst_n; req_valid/req_ready handshake per port; req_a (2x32),
//        req_shamt (2x5), req_dir, req_type, req_rot (rotate, only with
//        SHIFT_ARB_ROTATE_EN); rsp_valid per port, rsp_ready per port,
//        rsp_data shared result (registered, held until accepted).
// Macro SHIFT_ARB_ROTATE_EN: enables rotates, done as two shifter passes.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PORTS-1:0]       req_valid,
    output logic [NUM_PORTS-1:0]       req_ready,
    input  logic [NUM_PORTS*WIDTH-1:0] req_a,
    input  logic [NUM_PORTS*SHAMT_W-1:0] req_shamt,
    input  logic [NUM_PORTS-1:0]       req_dir,
    input  logic [NUM_PORTS-1:0]       req_type,
`ifdef SHIFT_ARB_ROTATE_EN
    input  logic [NUM_PORTS-1:0]       req_rot,
`endif
    output logic [NUM_PORTS-1:0]       rsp_valid,
    input  logic [NUM_PORTS-1:0]       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data
);

    state_e               state_r, state_s;
    logic                 owner_r, owner_s;
    logic [NUM_PORTS-1:0] rsp_valid_r, rsp_valid_s;
    logic [WIDTH-1:0]     rsp_data_r, rsp_data_s;

`ifdef SHIFT_ARB_ROTATE_EN
    logic [WIDTH-1:0]     op_r, op_s;
    logic [WIDTH-1:0]     partial_r, partial_s;
    logic [SHAMT_W-1:0]   shamt_r, shamt_s;
    logic                 rdir_r, rdir_s;
    logic                 g_rot_s;
`endif

    logic                 grant_s, grant_valid_s;
    logic                 can_accept_s, accept_s;
    logic [WIDTH-1:0]     g_a_s;
    logic [SHAMT_W-1:0]   g_shamt_s;
    logic                 g_dir_s, g_type_s;
    logic [WIDTH-1:0]     sh_a_s, sh_y_s;
    logic [SHAMT_W-1:0]   sh_shamt_s;
    logic                 sh_dir_s, sh_type_s;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_valid),
        .advance     (accept_s),
        .grant       (grant_s),
        .grant_valid (grant_valid_s)
    );

    Shifter u_shifter (
        .a     (sh_a_s),
        .shamt (sh_shamt_s),
        .dir   (sh_dir_s),
        .typ   (sh_type_s),
        .y     (sh_y_s)
    );

    // Accept window and the per-port ready that follows from it.
    always_comb begin
        can_accept_s = (state_r == IDLE) || ((state_r == HOLD) && rsp_ready[owner_r]);
        accept_s     = can_accept_s && grant_valid_s;
        if (accept_s) begin
            req_ready = port_onehot(grant_s);
        end else begin
            req_ready = 2'b00;
        end
    end

    // Select the granted port's request fields.
    always_comb begin
        if (grant_s) begin
            g_a_s     = req_a[2*WIDTH-1:WIDTH];
            g_shamt_s = req_shamt[2*SHAMT_W-1:SHAMT_W];
            g_dir_s   = req_dir[1];
            g_type_s  = req_type[1];
        end else begin
            g_a_s     = req_a[WIDTH-1:0];
            g_shamt_s = req_shamt[SHAMT_W-1:0];
            g_dir_s   = req_dir[0];
            g_type_s  = req_type[0];
        end
`ifdef SHIFT_ARB_ROTATE_EN
        g_rot_s = grant_s ? req_rot[1] : req_rot[0];
`endif
    end

    // Shifter input mux: latched rotate operand in PASS2, granted request otherwise.
    always_comb begin
`ifdef SHIFT_ARB_ROTATE_EN
        if (state_r == PASS2) begin
            sh_a_s     = op_r;
            sh_shamt_s = complement_shamt(shamt_r);
            sh_dir_s   = ~rdir_r;
            sh_type_s  = TYPE_LOGICAL;
        end else begin
            sh_a_s     = g_a_s;
            sh_shamt_s = g_shamt_s;
            sh_dir_s   = g_dir_s;
            // Both rotate passes are logical shifts.
            sh_type_s  = g_rot_s ? TYPE_LOGICAL : g_type_s;
        end
`else
        sh_a_s     = g_a_s;
        sh_shamt_s = g_shamt_s;
        sh_dir_s   = g_dir_s;
        sh_type_s  = g_type_s;
`endif
    end

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        rsp_valid_s = rsp_valid_r;
        rsp_data_s  = rsp_data_r;
`ifdef SHIFT_ARB_ROTATE_EN
        op_s        = op_r;
        partial_s   = partial_r;
        shamt_s     = shamt_r;
        rdir_s      = rdir_r;
`endif
        case (state_r)
            IDLE, HOLD: begin
                if (accept_s) begin
                    owner_s = grant_s;
`ifdef SHIFT_ARB_ROTATE_EN
                    if (g_rot_s) begin
                        // Pass 1 now; pass 2 next cycle from the latched operand.
                        state_s     = PASS2;
                        rsp_valid_s = 2'b00;
                        op_s        = g_a_s;
                        shamt_s     = g_shamt_s;
                        rdir_s      = g_dir_s;
                        partial_s   = sh_y_s;
                    end else begin
                        state_s     = HOLD;
                        rsp_valid_s = port_onehot(grant_s);
                        rsp_data_s  = sh_y_s;
                    end
`else
                    state_s     = HOLD;
                    rsp_valid_s = port_onehot(grant_s);
                    rsp_data_s  = sh_y_s;
`endif
                end else if ((state_r == HOLD) && rsp_ready[owner_r]) begin
                    state_s     = IDLE;
                    rsp_valid_s = 2'b00;
                end else begin
                    state_s     = state_r;
                end
            end
`ifdef SHIFT_ARB_ROTATE_EN
            PASS2: begin
                state_s     = HOLD;
                rsp_valid_s = port_onehot(owner_r);
                rsp_data_s  = partial_r | sh_y_s;
            end
`endif
            default: begin
                state_s     = IDLE;
                rsp_valid_s = 2'b00;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            owner_r     <= 1'b0;
            rsp_valid_r <= 2'b00;
            rsp_data_r  <= 32'h0000_0000;
`ifdef SHIFT_ARB_ROTATE_EN
            op_r        <= 32'h0000_0000;
            partial_r   <= 32'h0000_0000;
            shamt_r     <= 5'd0;
            rdir_r      <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_data_r  <= rsp_data_s;
`ifdef SHIFT_ARB_ROTATE_EN
            op_r        <= op_s;
            partial_r   <= partial_s;
            shamt_r     <= shamt_s;
            rdir_r      <= rdir_s;
`endif
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed cases plus randomized
// traffic scored against a transaction-level reference model.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_dir, req_type;
    logic [63:0] req_a;
    logic [9:0]  req_shamt;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
`ifdef SHIFT_ARB_ROTATE_EN
    logic [1:0]  req_rot;
`endif

    shift_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_shamt (req_shamt),
        .req_dir   (req_dir),
        .req_type  (req_type),
`ifdef SHIFT_ARB_ROTATE_EN
        .req_rot   (req_rot),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Requester-side pending requests (held until accepted).
    logic [1:0]  p_act;
    logic [31:0] p_a   [2];
    logic [4:0]  p_n   [2];
    logic        p_dir [2];
    logic        p_typ [2];
    logic        p_rot [2];

    // Reference model: at most one transaction in flight.
    logic        m_out;
    logic        m_port;
    logic [31:0] m_res;
    int          m_ready_cyc;
    logic        m_last;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    // Expected shifter result computed directly from the operation definition.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] n,
                                              input logic dir, input logic typ, input logic rot);
        logic [63:0] w;
        if (rot) begin
            w = {a, a};
            if (!dir) begin
                w = w << n;
                return w[63:32];
            end
            w = w >> n;
            return w[31:0];
        end
        if (!dir) return a << n;
        if (typ) begin
            w = {{32{a[31]}}, a};
            w = w >> n;
            return w[31:0];
        end
        return a >> n;
    endfunction

    task automatic drive();
        req_valid = p_act;
        req_a     = {p_a[1], p_a[0]};
        req_shamt = {p_n[1], p_n[0]};
        req_dir   = {p_dir[1], p_dir[0]};
        req_type  = {p_typ[1], p_typ[0]};
`ifdef SHIFT_ARB_ROTATE_EN
        req_rot   = {p_rot[1], p_rot[0]};
`endif
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [4:0] n,
                           input logic dir, input logic typ, input logic rot);
        p_act[p] = 1'b1;
        p_a[p] = a; p_n[p] = n; p_dir[p] = dir; p_typ[p] = typ; p_rot[p] = rot;
    endtask

    // One cycle: drive, check against the model, advance model across the edge.
    task automatic step();
        logic w, vis, can, any;
        logic [1:0] ev, er;
        drive();
        #1;
        any = p_act[0] | p_act[1];
        if (p_act[0] && p_act[1]) w = ~m_last;
        else w = p_act[1];
        vis = m_out && (cyc >= m_ready_cyc);
        ev  = vis ? onehot(m_port) : 2'b00;
        can = !m_out || (vis && rsp_ready[m_port]);
        er  = (can && any) ? onehot(w) : 2'b00;
        check_val("rsp_valid", {30'd0, rsp_valid}, {30'd0, ev});
        if (vis) check_val("rsp_data", rsp_data, m_res);
        check_val("req_ready", {30'd0, req_ready}, {30'd0, er});
        if (vis && rsp_ready[m_port]) m_out = 1'b0;
        if (can && any) begin
            m_out       = 1'b1;
            m_port      = w;
            m_res       = ref_shift(p_a[w], p_n[w], p_dir[w], p_typ[w], p_rot[w]);
            m_ready_cyc = cyc + (p_rot[w] ? 2 : 1);
            m_last      = w;
            p_act[w]    = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        p_act = 2'b00;
        rsp_ready = 2'b00;
        drive();
        rst_n = 1'b0;
        #1;
        check_val("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_val("rst_rsp_data", rsp_data, 32'd0);
        check_val("rst_req_ready", {30'd0, req_ready}, 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n  = 1'b1;
        m_out  = 1'b0;
        m_last = 1'b1;
    endtask

    // Single request with all others idle; checks latency and result.
    task automatic run_single(input string tag, input int p, input logic [31:0] a,
                              input logic [4:0] n, input logic dir, input logic typ,
                              input logic rot, input logic [31:0] exp, input int lat);
        rsp_ready = 2'b11;
        set_req(p, a, n, dir, typ, rot);
        step();
        for (int k = 1; k < lat; k++) begin
            check_val({tag, "_gap"}, {30'd0, rsp_valid}, 32'd0);
            step();
        end
        check_val({tag, "_valid"}, {30'd0, rsp_valid}, {30'd0, onehot(p[0])});
        check_val(tag, rsp_data, exp);
        step();
        check_val({tag, "_released"}, {30'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] exp0;
        rst_n = 1'b0;
        p_act = 2'b00;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            p_a[i] = 32'd0; p_n[i] = 5'd0; p_dir[i] = 1'b0; p_typ[i] = 1'b0; p_rot[i] = 1'b0;
        end
        m_out = 1'b0; m_port = 1'b0; m_res = 32'd0; m_ready_cyc = 0; m_last = 1'b1;
        drive();
        @(negedge clk);
        do_reset();

        // Port 0 arithmetic right shift.
        run_single("arith_right", 0, 32'h8000_0001, 5'd4, 1'b1, 1'b1, 1'b0, 32'hF800_0000, 1);

        // Both ports requesting every cycle: strict alternation from port 0.
        do_reset();
        rsp_ready = 2'b11;
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_act[p]) set_req(p, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end
            drive();
            #1;
            check_val("alt_grant", {30'd0, req_ready}, (i % 2 == 1) ? 32'd2 : 32'd1);
            if (i > 0) check_val("alt_result", {30'd0, rsp_valid}, ((i - 1) % 2 == 1) ? 32'd2 : 32'd1);
            step();
        end
        p_act = 2'b00;
        step();
        step();

        // Port 0 result held for three cycles while port 1 waits.
        do_reset();
        exp0 = ref_shift(32'hA5A5_0F0F, 5'd3, 1'b0, 1'b0, 1'b0);
        rsp_ready = 2'b00;
        set_req(0, 32'hA5A5_0F0F, 5'd3, 1'b0, 1'b0, 1'b0);
        step();
        set_req(1, 32'h0000_1234, 5'd1, 1'b1, 1'b0, 1'b0);
        rsp_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            drive();
            #1;
            check_val("hold_ready", {30'd0, req_ready}, 32'd0);
            check_val("hold_data", rsp_data, exp0);
            step();
        end
        rsp_ready = 2'b01;
        drive();
        #1;
        check_val("hold_release_accept", {30'd0, req_ready}, 32'd2);
        step();
        rsp_ready = 2'b11;
        check_val("hold_next_valid", {30'd0, rsp_valid}, 32'd2);
        step();
        step();

`ifdef SHIFT_ARB_ROTATE_EN
        run_single("rotl8", 0, 32'h1234_5678, 5'd8, 1'b0, 1'b0, 1'b1, 32'h3456_7812, 2);
        run_single("rotr8", 1, 32'h1234_5678, 5'd8, 1'b1, 1'b1, 1'b1, 32'h7812_3456, 2);
        run_single("rot0",  0, 32'h1234_5678, 5'd0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 2);
`endif
        run_single("left31", 0, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1);

        // Reset mid-operation (PASS2 with rotates, HOLD otherwise).
        rsp_ready = 2'b00;
`ifdef SHIFT_ARB_ROTATE_EN
        set_req(0, 32'hCAFE_F00D, 5'd4, 1'b0, 1'b0, 1'b1);
`else
        set_req(0, 32'h0000_00FF, 5'd4, 1'b0, 1'b0, 1'b0);
`endif
        step();
        do_reset();
        run_single("after_reset", 1, 32'h0F00_0000, 5'd4, 1'b1, 1'b0, 1'b0, 32'h00F0_0000, 1);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_act[p] && ($urandom % 3 == 0)) begin
`ifdef SHIFT_ARB_ROTATE_EN
                    set_req(p, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
`else
                    set_req(p, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'b0);
`endif
                end
            end
            rsp_ready[0] = ($urandom % 4) != 0;
            rsp_ready[1] = ($urandom % 4) != 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Sequencer and two-port arbiter for the processor's 32-bit combinational barrel shifter (module `Shifter`). It lets two requesters share one shifter instance: the ALU shift path is port 0, and the branch/immediate unit is port 1. Requests use valid/ready handshakes and are granted round-robin. Results are registered and held until the owning port accepts them.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; only 32 is supported (shamt is 5 bits).

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  2  request valid, one bit per port
- `req_ready`  out  2  request accepted this cycle, per port
- `req_a`  in  2x32  operand, per port
- `req_shamt`  in  2x5  shift amount, per port
- `req_dir`  in  2  per port: 0 = left, 1 = right
- `req_type`  in  2  per port: 0 = logical, 1 = arithmetic (ignored for left shifts and for rotates)
- `req_rot`  in  2  per port: 1 = rotate. Present only with `SHIFT_ARB_ROTATE_EN`.
- `rsp_valid`  out  2  result valid for the owning port
- `rsp_ready`  in  2  per-port result accept
- `rsp_data`  out  32  result, shared by both ports

## Operation
FSM states:
- IDLE: no result held.
- PASS2: second shifter pass of a rotate.
- HOLD: result registered and presented.

Acceptance and grant:
- The arbiter may accept a new request when `can_accept` is true. `can_accept` = (state == IDLE) or (state == HOLD and `rsp_ready[owner]`).
- Grant: if only one `req_valid` bit is set, that port wins. If both are set, the winner is the port not granted last. `last_grant` resets to 1, so port 0 wins the first tie.
- `req_ready[g]` = `can_accept` and grant to g. It is 0 for the other port.
- `last_grant` updates only on an actual accept.

Non-rotate request:
- The shifter computes the result in the accept cycle.
- The result is registered, `owner` is set to g, and the FSM goes to HOLD.

Rotate request (feature enabled):
- Pass 1, accept cycle: shift the operand by n (left for rotate-left, logical right for rotate-right) and store it in `partial`.
- Pass 2, in PASS2: shift the latched operand in the opposite direction, logical, by (32 − n) mod 32.
- The result is `partial` OR the pass-2 output. For n = 0 this gives the operand unchanged.
- The FSM then goes to HOLD.

Output and hold behaviour:
- `rsp_valid[owner]` = 1 in HOLD. `rsp_data` is the held result. All outputs are stable until `rsp_ready[owner]`.
- In HOLD, `rsp_ready` from the non-owner port is ignored.
- If a hold is released and a new request is accepted in the same cycle, the FSM goes straight back to HOLD (or to PASS2 for a rotate).
- If a hold is released with no new request, the FSM goes to IDLE.

Reset:
- `rsp_valid` = 0, `rsp_data` = 0, state = IDLE, `last_grant` = 1, `partial` = 0.
- `req_ready` depends combinationally on state, so it is 0 only while no `req_valid` bit is high.
- An asynchronous reset during PASS2 or HOLD discards the operation. The requester must reissue it.

## Timing
- Non-rotate latency: `rsp_valid` rises 1 cycle after the accepting edge.
- Rotate latency: `rsp_valid` rises 2 cycles after the accepting edge.
- Throughput with `rsp_ready` held high: 1 result per cycle for non-rotates, 1 per 2 cycles for rotates.
- `req_ready` combinationally depends on `req_valid`, `rsp_ready` and state. There is no combinational path from any `req_*` data input to `rsp_*` outputs.
- Requesters must hold `req_*` stable while `req_valid` is high and `req_ready` is low.

## Configuration
Macro: `SHIFT_ARB_ROTATE_EN`.
- Defined: the `req_rot` port, the PASS2 state, and the `partial` and operand latches exist. Rotates are supported as described above.
- Undefined: those items are removed. The FSM is IDLE/HOLD only, and every request completes in 1 cycle.

## Structure
- Package `shift_arb_pkg` holds:
  - the state enum (IDLE, PASS2, HOLD),
  - `NUM_PORTS` = 2,
  - `SHAMT_W` = 5,
  - the direction and type encodings (`DIR_LEFT`/`DIR_RIGHT`, `TYPE_LOGICAL`/`TYPE_ARITH`).
- Sub-module `rr_arb2`: a two-request round-robin grant with a `last_grant` register and an advance-on-accept input.
- `shift_arbiter` instantiates one `Shifter`. The shifter inputs are muxed: the granted port's request during accept, the latched rotate operand during PASS2.

## Test plan
- Port 0 only: a=0x8000_0001, shamt=4, right, arithmetic. Expect `rsp_valid[0]` the next cycle with data 0xF800_0000. `rsp_valid[1]` stays 0.
- Both ports valid every cycle with `rsp_ready`=2'b11. Expect grants alternating 0,1,0,1, starting with port 0 after reset. Expect one result per cycle, tagged to the correct port.
- Hold `rsp_ready[0]`=0 for 3 cycles with port 1 requesting. Expect `req_ready` = 0 throughout, `rsp_data` stable, and `rsp_ready[1]` ignored. When `rsp_ready[0]` rises, port 1 is accepted in that same cycle.
- Rotate enabled: a=0x1234_5678, shamt=8. Rotate-left gives 0x3456_7812 with 2-cycle latency. Rotate-right gives 0x7812_3456. shamt=0 returns 0x1234_5678.
- Rotate disabled: a=0xFFFF_FFFF, shamt=31, left, logical. Expect 0x8000_0000.
- Drop `rst_n` in PASS2. Expect all outputs reset immediately, IDLE after release, and the next request served normally.
